board_test_responder: RTL

//  Playfield owner and answering end of the piece-test interface. Accepts a candidate placement (4 cell indices, bbox, pos, rot)

---
 rtl/tetris_pkg.sv | 42 ++++
 rtl/board_row_shifter.sv | 34 +++
 rtl/board_test_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, move codes, FSM encoding and cell index helpers.
// No logic of its own; latency n/a.
// No flow control; pure definitions.
package tetris_pkg;
    localparam int COLS   = 8;
    localparam int ROWS   = 8;
    localparam int CELL_W = 6;
    localparam int ROW_W  = 3;
    localparam int COL_W  = 3;

    localparam logic [1:0] MOVE_LEFT  = 2'b00;
    localparam logic [1:0] MOVE_RIGHT = 2'b01;
    localparam logic [1:0] MOVE_ROT   = 2'b10;
    localparam logic [1:0] MOVE_DOWN  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_LOCK, ST_SCAN, ST_SHIFT, ST_RESP, ST_OVER
    } state_t;

    // row r occupies board[r]; bit c is column c, so the flat bit index equals the cell index
    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    function automatic logic [ROW_W-1:0] cell_row(input logic [CELL_W-1:0] idx);
        return ROW_W'(idx / CELL_W'(COLS));
    endfunction

    function automatic logic [COL_W-1:0] cell_col(input logic [CELL_W-1:0] idx);
        return COL_W'(idx % CELL_W'(COLS));
    endfunction

    function automatic logic [CELL_W-1:0] cell_idx(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return CELL_W'(row) * CELL_W'(COLS) + CELL_W'(col);
    endfunction

    function automatic board_t cell_mask(input logic [CELL_W-1:0] idx);
        board_t m;
        m = '0;
        m[cell_row(idx)][cell_col(idx)] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/board_row_shifter.sv
// Occupancy board storage: lock OR-in, per-row full flags, one-cycle collapse of row shift_row.
// Lock/shift take effect at the next clock edge; row_full is combinational from the stored board.
// No backpressure; shift_en has priority over lock_en.
module board_row_shifter
    import tetris_pkg::*;
(
    input  logic                 clk,
    input  logic                 restart_n,
    input  logic                 lock_en,
    input  board_t               lock_mask,
    input  logic                 shift_en,
    input  logic [ROW_W-1:0]     shift_row,
    output board_t               board,
    output logic [ROWS-1:0]      row_full
);
    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            board <= '0;
        end else if (shift_en) begin
            // every row at or above the cleared one drops by one; the top refills empty
            for (int r = 0; r < ROWS-1; r++) begin
                if (r >= int'(shift_row)) board[r] <= board[r+1];
            end
            board[ROWS-1] <= '0;
        end else if (lock_en) begin
            board <= board | lock_mask;
        end
    end

    always_comb begin
        row_full = '0;
        for (int r = 0; r < ROWS; r++) row_full[r] = &board[r];
    end
endmodule

// File: rtl/board_test_responder.sv
// Answers piece placement requests against the board: accept, reject, lock+row clear, or game over.
// Accept/reject pulse 2 cycles after request; lock path 3+ROWS+2*cleared_rows cycles.
// Requests are only sampled in IDLE; a held test_in_sig re-arms after each next_play_sig pulse.
module board_test_responder
    import tetris_pkg::*;
(
    input  logic                 clk,
    input  logic                 restart_n,
    input  logic                 test_in_sig,
    input  logic                 new_block_in_sig,
    input  logic [1:0]           move_in_sig,
    input  logic [CELL_W-1:0]    test_blk_1,
    input  logic [CELL_W-1:0]    test_blk_2,
    input  logic [CELL_W-1:0]    test_blk_3,
    input  logic [CELL_W-1:0]    test_blk_4,
    input  logic [2:0]           test_width,
    input  logic [2:0]           test_height,
    input  logic [3:0]           test_pos_x,
    input  logic [3:0]           test_pos_y,
    input  logic [1:0]           test_rot,
    output logic                 next_play_sig,
    output logic                 make_sig,
    output logic                 clear_sig,
    output logic                 over_sig,
    output logic [3:0]           cur_pos_x_out,
    output logic [3:0]           cur_pos_y_out,
    output logic [1:0]           cur_rot_out,
    input  logic [ROW_W-1:0]     disp_row_sel,
    output logic [COLS-1:0]      disp_row_data
);
    state_t              state, state_nxt;
    board_t              board, lat_mask, act_mask;
    logic [ROWS-1:0]     row_full;
    logic [2:0]          lat_w, lat_h;
    logic [3:0]          lat_x, lat_y;
    logic [1:0]          lat_rot, lat_move;
    logic                lat_new;
    logic [ROW_W-1:0]    scan_row;
    logic                make_r, clear_r;
    logic                hit, accept, lock_en, shift_en, scan_inc;

    board_row_shifter u_board (
        .clk       (clk),
        .restart_n (restart_n),
        .lock_en   (lock_en),
        .lock_mask (act_mask),
        .shift_en  (shift_en),
        .shift_row (scan_row),
        .board     (board),
        .row_full  (row_full)
    );

    // 5-bit sums so an origin near the edge cannot wrap back into range
    assign hit = (({2'b00, lat_w} + {1'b0, lat_x}) > 5'(COLS))
               | (({2'b00, lat_h} + {1'b0, lat_y}) > 5'(ROWS))
               | (|(lat_mask & board));

    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        lock_en   = 1'b0;
        shift_en  = 1'b0;
        scan_inc  = 1'b0;
        case (state)
            ST_IDLE:  if (test_in_sig) state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (!hit) begin
                    accept    = 1'b1;
                    state_nxt = ST_RESP;
                end else if (lat_new)              state_nxt = ST_OVER;
                else if (lat_move == MOVE_DOWN)    state_nxt = ST_LOCK;
                else                               state_nxt = ST_RESP;
            end
            ST_LOCK: begin
                lock_en   = 1'b1;
                state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (row_full[scan_row])                  state_nxt = ST_SHIFT;
                else if (scan_row == ROW_W'(ROWS-1))     state_nxt = ST_RESP;
                else                                     scan_inc  = 1'b1;
            end
            ST_SHIFT: begin
                shift_en  = 1'b1;
                state_nxt = ST_SCAN;
            end
            ST_RESP:  state_nxt = ST_IDLE;
            ST_OVER:  state_nxt = ST_OVER;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            lat_mask      <= '0;
            lat_w         <= '0;
            lat_h         <= '0;
            lat_x         <= '0;
            lat_y         <= '0;
            lat_rot       <= '0;
            lat_move      <= '0;
            lat_new       <= 1'b0;
            act_mask      <= '0;
            scan_row      <= '0;
            make_r        <= 1'b0;
            clear_r       <= 1'b0;
            cur_pos_x_out <= '0;
            cur_pos_y_out <= '0;
            cur_rot_out   <= '0;
        end else begin
            if (state == ST_IDLE && test_in_sig) begin
                lat_mask <= cell_mask(test_blk_1) | cell_mask(test_blk_2)
                          | cell_mask(test_blk_3) | cell_mask(test_blk_4);
                lat_w    <= test_width;
                lat_h    <= test_height;
                lat_x    <= test_pos_x;
                lat_y    <= test_pos_y;
                lat_rot  <= test_rot;
                lat_move <= move_in_sig;
                lat_new  <= new_block_in_sig;
            end
            if (accept) begin
                act_mask      <= lat_mask;
                cur_pos_x_out <= lat_x;
                cur_pos_y_out <= lat_y;
                cur_rot_out   <= lat_rot;
            end
            if (lock_en) begin
                act_mask <= '0;
                scan_row <= '0;
            end
            if (scan_inc) scan_row <= scan_row + 1'b1;
            if (state_nxt == ST_RESP) begin
                make_r  <= (state == ST_SCAN);
                clear_r <= 1'b0;
            end else if (state_nxt == ST_SHIFT) begin
                clear_r <= 1'b1;
            end
        end
    end

    assign next_play_sig = (state == ST_RESP);
    assign make_sig      = next_play_sig & make_r;
    assign clear_sig     = clear_r;
    assign over_sig      = (state == ST_OVER);
    assign disp_row_data = board[disp_row_sel] | act_mask[disp_row_sel];
endmodule
